// File: rtl/uart_hex_framer_pkg.sv
// Shared definitions for the hex framer: state encoding, ASCII constants and
// the nibble-to-character mapping used by hex_ascii_enc.
package uart_hex_framer_pkg;

    typedef logic [1:0] framer_state_t;

    localparam framer_state_t ST_IDLE       = 2'd0;
    localparam framer_state_t ST_SEND       = 2'd1;
    localparam framer_state_t ST_WAIT_START = 2'd2;
    localparam framer_state_t ST_WAIT_DONE  = 2'd3;

    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_SPACE   = 8'h20;

    // Letters are offset from 'A' or 'a', so subtract the decimal range first.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib, input logic upper);
        logic [7:0] result;
        logic [7:0] letterBase;
        letterBase = upper ? ASCII_UPPER_A : ASCII_LOWER_A;
        if (nib < 4'd10) begin
            result = ASCII_ZERO + {4'd0, nib};
        end else begin
            result = letterBase + {4'd0, nib} - 8'd10;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_hex_framer_hex_ascii_enc.sv
// Combinational 4-bit to ASCII hex digit encoder; UPPER picks the letter case.
module hex_ascii_enc
    import uart_hex_framer_pkg::*;
#(
    parameter bit UPPER = 1'b1
) (
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    assign ascii_o = nibble_to_ascii(nibble_i, UPPER);

endmodule

// File: rtl/uart_hex_framer.sv
// Prints one binary word as ASCII hex (MSB nibble first) plus a terminator to a
// UART transmitter. Define UART_HEX_FRAMER_CRLF_EN for a CR LF terminator, else a space.
module uart_hex_framer
    import uart_hex_framer_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter bit UPPER  = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic                  clk_50,
    input  logic                  clr,
    input  logic [4*DIGITS-1:0]   word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_wr,
    input  logic                  tx_busy,
    output logic                  frame_busy,
    output logic [CNT_W-1:0]      words_sent
);

`ifdef UART_HEX_FRAMER_CRLF_EN
    localparam int TERM_LEN = 2;
`else
    localparam int TERM_LEN = 1;
`endif
    localparam int WORD_W    = 4 * DIGITS;
    localparam int FRAME_LEN = DIGITS + TERM_LEN;
    localparam int IDX_W     = $clog2(FRAME_LEN + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] DIGITS_IDX = IDX_W'(DIGITS);

    framer_state_t      state_q, state_d;
    logic [WORD_W-1:0]  shift_q, shift_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_wr_q, tx_wr_d;
    logic               frame_busy_q, frame_busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [7:0]         hexChar;
    logic [7:0]         termChar;
    logic [7:0]         curChar;

    // The word shifts left after each character, so the top nibble is always next.
    hex_ascii_enc #(
        .UPPER(UPPER)
    ) u_enc (
        .nibble_i(shift_q[WORD_W-1 -: 4]),
        .ascii_o (hexChar)
    );

`ifdef UART_HEX_FRAMER_CRLF_EN
    assign termChar = (idx_q == DIGITS_IDX) ? ASCII_CR : ASCII_LF;
`else
    assign termChar = ASCII_SPACE;
`endif

    assign curChar = (idx_q < DIGITS_IDX) ? hexChar : termChar;

    // WAIT_START only needs tx_busy high, so a transmitter already busy is tolerated.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        tx_data_d    = tx_data_q;
        tx_wr_d      = 1'b0;
        frame_busy_d = frame_busy_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (word_valid) begin
                    shift_d      = word_in;
                    idx_d        = '0;
                    frame_busy_d = 1'b1;
                    state_d      = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_data_d = curChar;
                tx_wr_d   = 1'b1;
                state_d   = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d        = '0;
                        cnt_d        = cnt_q + CNT_W'(1);
                        frame_busy_d = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q << 4;
                        state_d = ST_SEND;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            idx_q        <= '0;
            tx_data_q    <= 8'h00;
            tx_wr_q      <= 1'b0;
            frame_busy_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            tx_data_q    <= tx_data_d;
            tx_wr_q      <= tx_wr_d;
            frame_busy_q <= frame_busy_d;
            cnt_q        <= cnt_d;
        end
    end

    assign word_ready = (state_q == ST_IDLE);
    assign tx_data    = tx_data_q;
    assign tx_wr      = tx_wr_q;
    assign frame_busy = frame_busy_q;
    assign words_sent = cnt_q;

endmodule
